// File: rtl/mdu_iter_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
// Pure declarations: no latency, no flow control.
// funct3 encodings, FSM state type and default datapath width.
package mdu_iter_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate of a double-width value plus word select.
// Combinational, zero latency.
// No flow control; shared by the multiply and divide result paths.
module mdu_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] val,
    input  logic              neg,
    input  logic              sel_hi,
    output logic [XLEN-1:0]   res
);

    logic [2*XLEN-1:0] fixed;

    assign fixed = neg ? -val : val;
    assign res   = sel_hi ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on magnitudes.
// Latency XLEN+1 cycles from issue to result (1 cycle for divide-by-zero/overflow).
// Stalls the pipeline while busy; a kill aborts the op and drops the stall at once.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic            m_type_stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_next;
    logic [XLEN-1:0]   opb_q;
    logic [2:0]        op_q;
    logic              neg_q;

    logic              start, finish;

    // Issue-time decode of the incoming op
    logic              is_div, rs1_signed, rs2_signed, s1, s2;
    logic              div_zero, div_ovf, special, neg_in;
    logic [XLEN-1:0]   mag1, mag2, special_res;

    always_comb begin
        is_div      = funct3_i[2];
        rs1_signed  = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        rs2_signed  = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        s1          = rs1_signed & rs1_i[XLEN-1];
        s2          = rs2_signed & rs2_i[XLEN-1];
        mag1        = s1 ? -rs1_i : rs1_i;
        mag2        = s2 ? -rs2_i : rs2_i;
        div_zero    = is_div && (rs2_i == '0);
        div_ovf     = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (rs1_i == MIN_NEG) && (rs2_i == '1);
        special     = div_zero | div_ovf;
        // Remainder takes the dividend's sign; everything else the sign product
        neg_in      = (is_div && funct3_i[1]) ? s1 : (s1 ^ s2);
        special_res = '0;
        if (div_zero)
            special_res = funct3_i[1] ? rs1_i : '1;
        else if (div_ovf)
            special_res = funct3_i[1] ? '0 : MIN_NEG;
    end

    // One iteration step; acc_q holds {hi, lo} for both algorithms
    logic [XLEN:0]     mul_sum, trial, diff;
    logic              qbit;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        trial    = acc_q[2*XLEN-1:XLEN-1];
        diff     = trial - {1'b0, opb_q};
        qbit     = ~diff[XLEN];
        div_next = {(qbit ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
        acc_next = op_q[2] ? div_next : mul_next;
    end

    logic [2*XLEN-1:0] fix_val;
    logic              fix_hi;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        fix_val = acc_next;
        fix_hi  = (op_q != F3_MUL);
        if (op_q[2]) begin
            fix_val = {{XLEN{1'b0}}, (op_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0])};
            fix_hi  = 1'b0;
        end
    end

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .val    (fix_val),
        .neg    (neg_q),
        .sel_hi (fix_hi),
        .res    (fix_res)
    );

    always_comb begin
        state_d        = state_q;
        m_type_stall_o = 1'b0;
        result_valid_o = 1'b0;
        start          = 1'b0;
        finish         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                m_type_stall_o = valid_i;
                if (valid_i) begin
                    start   = 1'b1;
                    state_d = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                m_type_stall_o = 1'b1;
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                result_valid_o = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill_i || rst_i) begin
            state_d        = ST_IDLE;
            m_type_stall_o = 1'b0;
            result_valid_o = 1'b0;
            start          = 1'b0;
            finish         = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= F3_MUL;
            neg_q    <= 1'b0;
            result_o <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                acc_q <= {{XLEN{1'b0}}, mag1};
                opb_q <= mag2;
                op_q  <= funct3_i;
                neg_q <= neg_in;
                cnt_q <= '0;
                if (special)
                    result_o <= special_res;
            end else if (state_q == ST_CALC) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish)
                result_o <= fix_res;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed checks of mdu_iter against a plain-arithmetic RV32M model.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, kill_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        m_type_stall_o, result_valid_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .kill_i         (kill_i),
        .m_type_stall_o (m_type_stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 32'd0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib, iq;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = 64'd0;
        iq = 0;
        case (f3)
            F3_MUL:    begin p = ua * ub; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) return 32'hffff_ffff;
                if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'h8000_0000;
                iq = ia / ib;
                return iq;
            end
            F3_DIVU:   return (b == 32'd0) ? 32'hffff_ffff : a / b;
            F3_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'd0;
                iq = ia % ib;
                return iq;
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Drives the op at the current negedge, follows it to DONE, ends at the next negedge
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int          stalls;
        bit          got;
        logic [31:0] exp;
        int          exp_st;
        exp    = ref_res(f3, a, b);
        exp_st = is_special(f3, a, b) ? 1 : 33;
        valid_i  = 1'b1;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        stalls   = 0;
        got      = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            #1;
            if (result_valid_o) begin
                got = 1'b1;
                chk($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result_o, exp);
                chk($sformatf("stall_cycles f3=%0d", f3), 32'(stalls), 32'(exp_st));
                chk("done_stall_low", 32'(m_type_stall_o), 32'd0);
            end else if (m_type_stall_o) begin
                stalls++;
            end
            @(negedge clk);
        end
        chk("result_timeout", 32'(got), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hffff_ffff;
            3:       return 32'h8000_0000;
            4:       return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    initial begin
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        kill_i   = 1'b0;
        funct3_i = 3'd0;
        rs1_i    = 32'd0;
        rs2_i    = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_stall", 32'(m_type_stall_o), 32'd0);
        chk("reset_rv", 32'(result_valid_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        run_op(F3_MUL, 32'd7, 32'hffff_fffd);
        run_op(F3_MULH, 32'h8000_0000, 32'h8000_0000);
        run_op(F3_MULHU, 32'hffff_ffff, 32'hffff_ffff);
        run_op(F3_MULHSU, 32'hffff_fffe, 32'h0000_0003);
        run_op(F3_DIV, 32'hffff_fff9, 32'd2);
        run_op(F3_REM, 32'hffff_fff9, 32'd2);
        run_op(F3_DIVU, 32'hffff_fff9, 32'd2);
        run_op(F3_DIVU, 32'd100, 32'd0);
        run_op(F3_REMU, 32'd100, 32'd0);
        run_op(F3_DIV, 32'h8000_0000, 32'hffff_ffff);
        run_op(F3_REM, 32'h8000_0000, 32'hffff_ffff);

        // Kill on CALC iteration 10 (cycle T+11), then a fresh op right after
        valid_i  = 1'b1;
        funct3_i = F3_MUL;
        rs1_i    = 32'd12345;
        rs2_i    = 32'd678;
        repeat (11) @(negedge clk);
        #1;
        chk("pre_kill_stall", 32'(m_type_stall_o), 32'd1);
        kill_i = 1'b1;
        #1;
        chk("kill_stall", 32'(m_type_stall_o), 32'd0);
        chk("kill_rv", 32'(result_valid_o), 32'd0);
        @(negedge clk);
        kill_i = 1'b0;
        run_op(F3_MUL, 32'd3, 32'd5);

        // One-cycle reset in the middle of CALC
        valid_i  = 1'b1;
        funct3_i = F3_DIV;
        rs1_i    = 32'd1000;
        rs2_i    = 32'd7;
        repeat (6) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("rst_cycle_stall", 32'(m_type_stall_o), 32'd0);
        @(negedge clk);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("post_rst_stall", 32'(m_type_stall_o), 32'd0);
        chk("post_rst_rv", 32'(result_valid_o), 32'd0);
        chk("post_rst_result", result_o, 32'd0);
        @(negedge clk);
        run_op(F3_DIVU, 32'd9, 32'd3);

        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op(rf3, ra, rb);
        end

        // Reset and kill together: reset still clears the held result
        run_op(F3_MULHU, 32'hdead_beef, 32'h1234_5678);
        valid_i  = 1'b1;
        funct3_i = F3_REMU;
        rs1_i    = 32'd77;
        rs2_i    = 32'd5;
        repeat (4) @(negedge clk);
        rst_i  = 1'b1;
        kill_i = 1'b1;
        @(negedge clk);
        rst_i   = 1'b0;
        kill_i  = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("rst_kill_result", result_o, 32'd0);
        chk("rst_kill_rv", 32'(result_valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit in the EX stage. Accepts one M-type op per issue, computes it over multiple cycles, and drives `m_type_stall_o`, which feeds the hazard unit's M-type stall input to freeze PC, IF/ID and ID/EX until the result is ready. It honours a kill from the pipeline, so a flushed M-op never produces a result.

## Interface
- `XLEN`, 32: operand/result width. Only 32 is supported.
- `CNT_W`, 6: iteration counter width. Must satisfy 2^CNT_W > XLEN.

- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  an M-type instruction occupies EX; held stable while stalled.
- `funct3_i`  in  3  RV32M op: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `rs1_i`  in  XLEN  operand A; stable while `valid_i` is high.
- `rs2_i`  in  XLEN  operand B; stable while `valid_i` is high.
- `kill_i`  in  1  flush of the EX instruction; aborts any operation.
- `m_type_stall_o`  out  1  pipeline stall request (combinational).
- `result_o`  out  XLEN  registered result.
- `result_valid_o`  out  1  `result_o` belongs to the EX instruction this cycle.

## Operation
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - If `valid_i & ~kill_i`, latch operand magnitudes, sign flags and op, and clear the counter.
  - If the op is a divide by zero, or a signed overflow (DIV/REM with -2^31 / -1), go to DONE with the special result preloaded.
  - Otherwise go to CALC.
- CALC: one iteration per cycle for XLEN cycles. When the counter reaches XLEN-1, go to DONE on the next edge and apply sign correction into `result_o`.
- DONE: unconditionally return to IDLE. The pipeline advances this cycle, so a new M-op can be seen in IDLE on the very next cycle.
- Multiply uses shift-add on a 2·XLEN accumulator.
  - Signs: MULH treats both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU and MUL treat both as unsigned.
  - The product is negated when the signs differ.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- Divide uses restoring division on operand magnitudes.
  - Quotient sign is s1^s2; remainder sign is s1 (signed ops only).
- Special results:
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Overflow: quotient = 0x80000000, remainder = 0.
- Kill: if `kill_i` is high in any state, the next state is IDLE and the latched op is discarded.
- Reset: on `rst_i`, the next state is IDLE, the counter is 0 and `result_o` is 0.

## Timing
- `m_type_stall_o` = `~rst_i & ~kill_i & ((IDLE & valid_i) | CALC)`. It is low in DONE.
- Normal op issued in cycle T:
  - Stall is high in cycles T..T+XLEN (33 cycles).
  - In cycle T+XLEN+1 (DONE), `result_valid_o`=1 and stall=0.
- Special-case op issued in cycle T: stall is high in T only; DONE is cycle T+1.
- `result_valid_o` = `DONE & ~kill_i`.
- `result_o` holds its value until the next DONE entry, and is zeroed by reset.
- Reset values: state IDLE, `m_type_stall_o`=0, `result_valid_o`=0, `result_o`=0.
- Kill in cycle K drops stall in cycle K. The unit is in IDLE at K+1, and a new `valid_i` in K+1 starts a fresh op.
- Back-to-back M-ops: DONE at cycle D and the next op's issue at D+1. There is no bubble beyond DONE.
- Simultaneous `rst_i` and `kill_i`: reset wins (result is zeroed).

## Structure
- `defines.v` gets:
  - the RV32M `funct3` constants (`MUL` through `REMU`);
  - the FSM state encodings (IDLE=0, CALC=1, DONE=2);
  - the `XLEN` default.
- One sub-module, `mdu_sign_fix`: a combinational conditional-negate plus high/low select, shared by the multiply and divide result paths.
- The iteration datapath (accumulator, shifted multiplicand/divisor, counter) lives in `mdu_iter`.

## Test plan
- MUL with rs1=7, rs2=0xFFFFFFFD (-3) -> stall high 33 cycles, then `result_valid_o`=1 and `result_o`=0xFFFFFFEB.
- MULH with 0x80000000 × 0x80000000 -> 0x40000000. MULHU with 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE, issued back-to-back with the MULH in the cycle after its DONE.
- DIV with -7 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU with 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIVU 100/0 -> 0xFFFFFFFF, and REMU 100/0 -> 100, each with exactly one stall cycle. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM with the same operands -> 0, each with one stall cycle.
- Kill during CALC iteration 10 -> stall drops the same cycle, no `result_valid_o`, IDLE next cycle. A following MUL 3×5 -> 15.
- `rst_i` asserted mid-CALC for 1 cycle -> all outputs 0 the next cycle, and a subsequent DIVU 9/3 -> 3.
